fib_mem_responder: RTL and testbench

Memory-side responder for the Fibonacci datapath's memory FSM. It accepts single-word read/write requests (15-bit address, 16-bit data) over a req/ack pulse handshake, sequences them onto a synchronous single-port block RAM with one-cycle read latency, and returns read data. It also range-checks addresses and keeps saturating access counters for the verification bench and the top-level debug display.

---
 rtl/fib_mem_responder.sv | 76 +++++++
 tb/tb_fib_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_mem_responder.sv
// fib_mem_responder: req/ack memory responder sequencing single-word reads/writes onto a 1-cycle-latency sync RAM
// Ports: clk/clr (async active-low reset); req/we/address/wdata request, sampled in IDLE;
// ack/err one-cycle completion pulses; rdata last read word; busy = not IDLE;
// ram_addr/ram_we/ram_din/ram_dout RAM side; rd_count/wr_count saturating success counters.
module fib_mem_responder #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int ADDR_LIMIT = 32767
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, ERR} state_t;
  localparam logic [31:0] LIM = 32'(ADDR_LIMIT);
  state_t state;
  logic oor;
  assign oor = 32'(address) > LIM;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      ack <= 1'b0;
      err <= 1'b0;
      ram_we <= 1'b0;
      rdata <= '0;
      ram_addr <= '0;
      ram_din <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: if (req) begin
          ram_addr <= address;
          ram_din <= wdata;
          ram_we <= we && !oor;
          state <= oor ? ERR : (we ? WRITE : READ);
        end
        WRITE: begin
          ack <= 1'b1;
          wr_count <= wr_count + 16'(wr_count != 16'hFFFF);
          state <= IDLE;
        end
        READ: state <= READ_WAIT;
        READ_WAIT: begin
          rdata <= ram_dout;
          ack <= 1'b1;
          rd_count <= rd_count + 16'(rd_count != 16'hFFFF);
          state <= IDLE;
        end
        ERR: begin
          ack <= 1'b1;
          err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_mem_responder.sv
// tb_fib_mem_responder: randomized self-checking bench for fib_mem_responder against a transaction-level model
module tb_fib_mem_responder;
  localparam int LIM = 1023;
  logic clk = 0, clr = 0, req = 0, we = 0;
  logic [14:0] address = '0;
  logic [15:0] wdata = '0;
  logic ack, err, busy, ram_we;
  logic [15:0] rdata, ram_din, ram_dout, rd_count, wr_count;
  logic [14:0] ram_addr;
  logic [15:0] ram [32768] = '{default: '0};
  logic [15:0] ref_mem [32768] = '{default: '0};
  logic [15:0] m_rd = '0, m_wr = '0, m_rdata = '0;
  int checks = 0, errors = 0;

  fib_mem_responder #(.ADDR_W(15), .DATA_W(16), .ADDR_LIMIT(LIM)) dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .address(address), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Transaction-level expectation: latency in edges after the accepting edge, error flag, memory and counters.
  task automatic model(input logic w, input logic [14:0] a, input logic [15:0] d, output int lat, output logic e);
    e = int'(a) > LIM;
    lat = (e || w) ? 1 : 2;
    if (!e && w) begin
      ref_mem[a] = d;
      if (m_wr != 16'hFFFF) m_wr++;
    end else if (!e) begin
      m_rdata = ref_mem[a];
      if (m_rd != 16'hFFFF) m_rd++;
    end
  endtask

  task automatic issue(input logic w, input logic [14:0] a, input logic [15:0] d,
                       output int lat, output logic e, output int wecnt);
    @(negedge clk);
    req = 1; we = w; address = a; wdata = d;
    @(posedge clk); #1;
    req = 0; lat = 0; wecnt = 0;
    while (!ack && lat < 8) begin
      wecnt += int'(ram_we);
      @(posedge clk); #1;
      lat++;
    end
    e = err;
  endtask

  task automatic test_reset();
    clr = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req = 1'($urandom); we = 1'($urandom); address = 15'($urandom); wdata = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({ack, err, busy, ram_we, rdata, ram_addr, ram_din, rd_count, wr_count} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d ack=%b err=%b busy=%b ram_we=%b rdata=%h ram_addr=%h ram_din=%h rd=%h wr=%h expected all 0",
                 i, ack, err, busy, ram_we, rdata, ram_addr, ram_din, rd_count, wr_count);
      end
    end
    @(negedge clk);
    req = 0; we = 0;
    clr = 1;
    m_rd = 0; m_wr = 0; m_rdata = 0;
  endtask

  task automatic test_write_read();
    logic w [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [14:0] a [4] = '{15'd0, 15'd1, 15'd2, 15'd2};
    logic [15:0] d [4] = '{16'h0001, 16'h0001, 16'h0002, 16'h0000};
    int lat, el, wc;
    logic e, ee;
    for (int i = 0; i < 4; i++) begin
      model(w[i], a[i], d[i], el, ee);
      issue(w[i], a[i], d[i], lat, e, wc);
      checks++;
      if (lat !== el || e !== ee || wc !== int'(w[i])) begin
        errors++;
        $display("FAIL wr_rd_timing op %0d lat=%0d err=%b we_cycles=%0d expected lat=%0d err=%b we_cycles=%0d",
                 i, lat, e, wc, el, ee, int'(w[i]));
      end
    end
    checks++;
    if (rdata !== 16'h0002) begin
      errors++;
      $display("FAIL wr_rd_rdata got %h expected 0002", rdata);
    end
    checks++;
    if (wr_count !== 16'd3 || rd_count !== 16'd1) begin
      errors++;
      $display("FAIL wr_rd_counts wr=%0d rd=%0d expected wr=3 rd=1", wr_count, rd_count);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_deassert ack=%b err=%b busy=%b expected 0 0 0", ack, err, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4] = '{16'd1, 16'd1, 16'd2, 16'd3};
    int lat, el, wc, n, last, stray;
    logic e, ee;
    for (int i = 0; i < 4; i++) begin
      model(1'b1, 15'(i), vals[i], el, ee);
      issue(1'b1, 15'(i), vals[i], lat, e, wc);
    end
    @(negedge clk);
    req = 1; we = 0; address = 0;
    n = 0; last = -1; stray = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      @(posedge clk); #1;
      stray += int'(ram_we);
      if (ack) begin
        checks++;
        if (rdata !== vals[n] || (n == 0 ? c != 2 : c - last != 3)) begin
          errors++;
          $display("FAIL b2b_read %0d rdata=%h edge=%0d prev=%0d expected rdata=%h spacing 3", n, rdata, c, last, vals[n]);
        end
        model(1'b0, 15'(n), 16'h0, el, ee);
        last = c;
        n++;
      end
      @(negedge clk);
      if (ack) begin
        we = 0; address = 15'(n);
      end else begin
        we = 1; address = 15'($urandom); wdata = 16'($urandom);
      end
      if (n == 4) req = 0;
    end
    req = 0; we = 0;
    checks++;
    if (n !== 4 || stray !== 0 || rd_count !== m_rd) begin
      errors++;
      $display("FAIL b2b_summary acks=%0d stray_writes=%0d rd_count=%0d expected 4 0 %0d", n, stray, rd_count, m_rd);
    end
  endtask

  task automatic test_range();
    int lat, el, wc;
    logic e, ee;
    logic [15:0] r0, w0, d0;
    r0 = rd_count; w0 = wr_count; d0 = rdata;
    model(1'b1, 15'd1024, 16'h0637, el, ee);
    issue(1'b1, 15'd1024, 16'h0637, lat, e, wc);
    checks++;
    if (lat !== 1 || e !== 1'b1 || wc !== 0) begin
      errors++;
      $display("FAIL range_reject lat=%0d err=%b we_cycles=%0d expected 1 1 0", lat, e, wc);
    end
    checks++;
    if (rd_count !== r0 || wr_count !== w0 || rdata !== d0) begin
      errors++;
      $display("FAIL range_state rd=%0d wr=%0d rdata=%h expected %0d %0d %h", rd_count, wr_count, rdata, r0, w0, d0);
    end
    model(1'b0, 15'd1023, 16'h0, el, ee);
    issue(1'b0, 15'd1023, 16'h0, lat, e, wc);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rdata !== m_rdata || rd_count !== m_rd) begin
      errors++;
      $display("FAIL range_edge_read lat=%0d err=%b rdata=%h rd=%0d expected 2 0 %h %0d", lat, e, rdata, rd_count, m_rdata, m_rd);
    end
  endtask

  task automatic test_random();
    int lat, el, wc;
    logic e, ee, w;
    logic [14:0] a;
    logic [15:0] d;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = 15'($urandom_range(1000, 1040));
      d = 16'($urandom);
      model(w, a, d, el, ee);
      issue(w, a, d, lat, e, wc);
      checks++;
      if (lat !== el || e !== ee || wc !== int'(w && !ee) || rdata !== m_rdata ||
          rd_count !== m_rd || wr_count !== m_wr) begin
        errors++;
        $display("FAIL random_op %0d w=%b a=%0d lat=%0d err=%b wec=%0d rdata=%h rd=%0d wr=%0d expected lat=%0d err=%b wec=%0d rdata=%h rd=%0d wr=%0d",
                 i, w, a, lat, e, wc, rdata, rd_count, wr_count, el, ee, int'(w && !ee), m_rdata, m_rd, m_wr);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, el, wc, acks;
    logic e, ee;
    @(negedge clk);
    req = 1; we = 1; address = 15'd5; wdata = 16'h5555;
    @(posedge clk); #1;
    req = 0; we = 0;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL midwr_we_high ram_we=%b expected 1", ram_we);
    end
    clr = 0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midwr_async ram_we=%b busy=%b wr=%0d expected 0 0 0", ram_we, busy, wr_count);
    end
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      acks += int'(ack);
    end
    @(negedge clk);
    clr = 1;
    m_rd = 0; m_wr = 0; m_rdata = 0;
    @(posedge clk); #1;
    acks += int'(ack);
    checks++;
    if (acks !== 0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midwr_no_ack acks=%0d wr=%0d expected 0 0", acks, wr_count);
    end
    model(1'b0, 15'd5, 16'h0, el, ee);
    issue(1'b0, 15'd5, 16'h0, lat, e, wc);
    checks++;
    if (rdata !== m_rdata || lat !== 2) begin
      errors++;
      $display("FAIL midwr_mem rdata=%h lat=%0d expected %h 2", rdata, lat, m_rdata);
    end
  endtask

  task automatic test_saturation();
    int lat, el, wc;
    logic e, ee;
    @(negedge clk);
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    m_wr = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      model(1'b1, 15'(20 + i), 16'(i), el, ee);
      issue(1'b1, 15'(20 + i), 16'(i), lat, e, wc);
      checks++;
      if (wr_count !== m_wr || wr_count !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_write %0d wr=%h expected %h", i, wr_count, m_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_range();
    test_random();
    test_reset_mid_write();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
